// File: rtl/input_frontend.sv
// Button front end: synchronises the direct buttons and the serial gamepad
// pmod, deserialises the gamepad frame, debounces all 32 button bits on a
// shared sample tick and produces one-cycle press pulses.
module input_frontend #(
  parameter int SAMPLE_DIV = 4096,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  btn_in,
  input  logic        pmod_data,
  input  logic        pmod_clk,
  input  logic        pmod_latch,
  output logic [31:0] held_down,
  output logic [31:0] just_pressed
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  // Synchroniser stages: {latch, clk, data, btn[7:0]}
  logic [10:0]             sync1_q;
  logic [10:0]             sync2_q;

  logic [7:0]              btn_s;
  logic                    data_s;
  logic                    pclk_s;
  logic                    plat_s;

  logic                    pclk_prev_q;
  logic                    plat_prev_q;
  logic                    pclk_rise;
  logic                    plat_rise;

  logic [23:0]             sr_q;
  logic [23:0]             sr_d;
  logic [23:0]             gp_raw_q;
  logic [23:0]             gp_raw_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    tick;

  logic [31:0]             raw;
  logic [31:0][DEPTH-1:0]  hist_q;
  logic [31:0][DEPTH-1:0]  hist_d;
  logic [31:0]             held_q;
  logic [31:0]             held_d;
  logic [31:0]             held_prev_q;
  logic [31:0]             pulse_q;
  logic [31:0]             pulse_d;

  // Two-flop synchronisers for every asynchronous pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pmod_latch, pmod_clk, pmod_data, btn_in};
      sync2_q <= sync1_q;
    end
  end

  assign btn_s  = sync2_q[7:0];
  assign data_s = sync2_q[8];
  assign pclk_s = sync2_q[9];
  assign plat_s = sync2_q[10];

  assign pclk_rise = pclk_s & ~pclk_prev_q;
  assign plat_rise = plat_s & ~plat_prev_q;

  // Deserialiser: latch captures the pre-shift register even when a shift
  // edge lands in the same cycle
  always_comb begin
    sr_d     = sr_q;
    gp_raw_d = gp_raw_q;
    if (plat_rise) gp_raw_d = sr_q;
    if (pclk_rise) sr_d = {sr_q[22:0], data_s};
  end

  // Shared debounce sample tick, last count of each prescaler period
  assign tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // Raw vector ordering puts pad 1 above the direct buttons, pad 2 on top
  assign raw = {gp_raw_q[11:0], gp_raw_q[23:12], btn_s};

  // Debounce: a bit changes only after DEPTH agreeing samples
  always_comb begin
    hist_d = hist_q;
    held_d = held_q;
    if (tick) begin
      for (int i = 0; i < 32; i++) begin
        hist_d[i] = {hist_q[i][DEPTH-2:0], raw[i]};
        if (&hist_d[i])       held_d[i] = 1'b1;
        else if (~|hist_d[i]) held_d[i] = 1'b0;
      end
    end
  end

  // Press pulse appears the cycle after the debounced level rises
  assign pulse_d = held_q & ~held_prev_q;

  // State registers for deserialiser, prescaler, debounce and press detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_prev_q <= 1'b0;
      plat_prev_q <= 1'b0;
      sr_q        <= '0;
      gp_raw_q    <= '0;
      cnt_q       <= '0;
      hist_q      <= '0;
      held_q      <= '0;
      held_prev_q <= '0;
      pulse_q     <= '0;
    end else begin
      pclk_prev_q <= pclk_s;
      plat_prev_q <= plat_s;
      sr_q        <= sr_d;
      gp_raw_q    <= gp_raw_d;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      held_q      <= held_d;
      held_prev_q <= held_q;
      pulse_q     <= pulse_d;
    end
  end

  assign held_down    = held_q;
  assign just_pressed = pulse_q;

endmodule

// File: tb/tb_input_frontend.sv
// Self-checking bench for input_frontend with a behavioural reference model.
module tb_input_frontend;

  localparam int SD = 4;
  localparam int DP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  btn_in = '0;
  logic        pmod_data = 1'b0;
  logic        pmod_clk = 1'b0;
  logic        pmod_latch = 1'b0;
  logic [31:0] held_down;
  logic [31:0] just_pressed;

  int checks = 0;
  int errors = 0;

  input_frontend #(.SAMPLE_DIV(SD), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .pmod_data    (pmod_data),
    .pmod_clk     (pmod_clk),
    .pmod_latch   (pmod_latch),
    .held_down    (held_down),
    .just_pressed (just_pressed)
  );

  always #5 clk = ~clk;

  // Reference model: inputs delayed two clocks, the last DP sampled raw
  // vectors kept as a list, level = all-ones / all-zeros over that list.
  logic [10:0] m_inq[$];
  logic [31:0] m_samp [DP];
  logic [23:0] m_sr, m_gp;
  logic        m_pclk_prev, m_plat_prev;
  int          m_cnt, m_ticks;
  logic [31:0] m_held, m_heldd, m_jp;

  always @(posedge clk) begin : model
    logic [10:0] s;
    logic [31:0] raw, all1, any1;
    if (!rst_n) begin
      m_inq.delete();
      m_inq.push_back(11'd0);
      m_inq.push_back(11'd0);
      for (int i = 0; i < DP; i++) m_samp[i] = '0;
      m_sr = '0; m_gp = '0; m_pclk_prev = 1'b0; m_plat_prev = 1'b0;
      m_cnt = 0; m_held = '0; m_heldd = '0; m_jp = '0;
    end else begin
      s = m_inq.pop_front();
      m_inq.push_back({pmod_latch, pmod_clk, pmod_data, btn_in});
      raw = {m_gp[11:0], m_gp[23:12], s[7:0]};
      m_jp = m_held & ~m_heldd;
      m_heldd = m_held;
      if (m_cnt == SD - 1) begin
        m_ticks = m_ticks + 1;
        for (int i = DP - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = raw;
        all1 = '1; any1 = '0;
        for (int i = 0; i < DP; i++) begin
          all1 = all1 & m_samp[i];
          any1 = any1 | m_samp[i];
        end
        m_held = (m_held | all1) & any1;
      end
      m_cnt = (m_cnt + 1) % SD;
      if (s[10] && !m_plat_prev) m_gp = m_sr;
      if (s[9] && !m_pclk_prev) m_sr = {m_sr[22:0], s[8]};
      m_plat_prev = s[10];
      m_pclk_prev = s[9];
    end
  end

  // Stimulus helpers (no checking)
  task automatic shift_bit(input logic b);
    pmod_data = b;
    repeat (3) @(negedge clk);
    pmod_clk = 1'b1;
    repeat (3) @(negedge clk);
    pmod_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic latch_frame();
    pmod_latch = 1'b1;
    repeat (3) @(negedge clk);
    pmod_latch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = '0; pmod_latch = 1'b0; pmod_clk = 1'b0; pmod_data = 1'b0;
    m_ticks = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (held_down !== 32'h0 || just_pressed !== 32'h0) begin
      errors++;
      $display("FAIL reset_in got held=%h jp=%h want 0 0", held_down, just_pressed);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (held_down !== 32'h0 || just_pressed !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got held=%h jp=%h want 0 0", c, held_down, just_pressed);
      end
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    btn_in = 8'h10;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL hold_model cyc %0d got %h/%h want %h/%h", c, held_down, just_pressed, m_held, m_jp);
      end
      if (just_pressed === 32'h10) pulses++;
    end
    checks++;
    if (held_down !== 32'h10) begin
      errors++;
      $display("FAIL hold_level got %h want %h", held_down, 32'h10);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_bounce();
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    btn_in = '0;
    for (int c = 0; c < 8 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL release_model cyc %0d got %h/%h want %h/%h", c, held_down, just_pressed, m_held, m_jp);
      end
    end
    checks++;
    if (held_down !== 32'h0) begin
      errors++;
      $display("FAIL release_level got %h want 0", held_down);
    end
    for (int s = 0; s < 9; s++) begin
      int last = m_ticks;
      int n = 0;
      while (m_ticks == last && n < 2 * SD) begin
        @(negedge clk);
        n++;
        checks++;
        if (held_down[0] !== 1'b0 || just_pressed[0] !== 1'b0 ||
            held_down !== m_held || just_pressed !== m_jp) begin
          errors++;
          $display("FAIL bounce step %0d got %h/%h want %h/%h (bit0 must stay 0)", s, held_down, just_pressed, m_held, m_jp);
        end
      end
      if (m_ticks == last) begin
        errors++;
        $display("FAIL bounce_tick_timeout step %0d got no tick want tick", s);
      end
      btn_in[0] = pat[s];
    end
  endtask

  task automatic test_frame();
    int pulses = 0;
    shift_bit(1'b0);
    for (int b = 0; b < 23; b++) shift_bit(1'b1);
    latch_frame();
    for (int c = 0; c < 6 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL frame_model cyc %0d got %h/%h want %h/%h", c, held_down, just_pressed, m_held, m_jp);
      end
      if (just_pressed === 32'hFFF7FF00) pulses++;
    end
    checks++;
    if (held_down !== 32'hFFF7FF00) begin
      errors++;
      $display("FAIL frame_level got %h want %h", held_down, 32'hFFF7FF00);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL frame_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_both_edges();
    logic [23:0] v = 24'hABCDEF;
    for (int b = 23; b >= 0; b--) shift_bit(v[b]);
    pmod_data = 1'b0;
    repeat (3) @(negedge clk);
    pmod_clk = 1'b1;
    pmod_latch = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.gp_raw_q !== 24'hABCDEF || dut.gp_raw_q !== m_gp) begin
      errors++;
      $display("FAIL both_gp_raw got %h want %h", dut.gp_raw_q, 24'hABCDEF);
    end
    // one shift of ABCDEF with a 0 shifted in, truncated to 24 bits
    checks++;
    if (dut.sr_q !== 24'h579BDE || dut.sr_q !== m_sr) begin
      errors++;
      $display("FAIL both_sr got %h want %h", dut.sr_q, 24'h579BDE);
    end
    pmod_clk = 1'b0;
    pmod_latch = 1'b0;
    for (int c = 0; c < 6 * SD; c++) begin
      @(negedge clk);
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL both_model cyc %0d got %h/%h want %h/%h", c, held_down, just_pressed, m_held, m_jp);
      end
    end
    checks++;
    if (held_down !== 32'hDEFABC00) begin
      errors++;
      $display("FAIL both_level got %h want %h", held_down, 32'hDEFABC00);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int len;
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(20, 28);
        for (int b = 0; b < len; b++) shift_bit(1'($urandom_range(0, 1)));
        latch_frame();
      end
      btn_in = 8'($urandom);
      len = $urandom_range(1, 16);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        checks++;
        if (held_down !== m_held || just_pressed !== m_jp) begin
          errors++;
          $display("FAIL random it %0d got %h/%h want %h/%h", it, held_down, just_pressed, m_held, m_jp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int pulses = 0;
    btn_in = 8'h40;
    while (held_down[6] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL rmid_pre got %h/%h want %h/%h", held_down, just_pressed, m_held, m_jp);
      end
    end
    checks++;
    if (held_down[6] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_hold_timeout got %b want 1", held_down[6]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (held_down !== 32'h0 || just_pressed !== 32'h0) begin
      errors++;
      $display("FAIL rmid_reset got %h/%h want 0 0", held_down, just_pressed);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (just_pressed !== 32'h0) begin
          errors++;
          $display("FAIL rmid_after got %h want 0", just_pressed);
        end
      end
      checks++;
      if (held_down !== m_held || just_pressed !== m_jp) begin
        errors++;
        $display("FAIL rmid_model cyc %0d got %h/%h want %h/%h", c, held_down, just_pressed, m_held, m_jp);
      end
      if (just_pressed[6] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || held_down !== 32'h40) begin
      errors++;
      $display("FAIL rmid_pulse got pulses=%0d held=%h want 1 %h", pulses, held_down, 32'h40);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_bounce();
    test_frame();
    test_both_edges();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
